// File: rtl/fetch_pc_ctrl_if.sv
// Fetch next-PC controller bus: execute redirect/training inputs,
// mini-decode results, and the fetch PC/valid/prediction outputs.
interface fetch_pc_ctrl_if #(
    parameter int PC_WIDTH = 32
);
    logic                F_stall_i;
    logic                E_redirect_i;
    logic [PC_WIDTH-1:0] E_redirect_pc_i;
    logic                E_train_valid_i;
    logic [PC_WIDTH-1:0] E_train_pc_i;
    logic                E_train_taken_i;
    logic                mini_op_branch_i;
    logic                mini_op_jal_i;
    logic [PC_WIDTH-1:0] mini_jal_jmp_i;
    logic [PC_WIDTH-1:0] mini_branch_jmp_i;
    logic [PC_WIDTH-1:0] F_PC_o;
    logic                F_valid_o;
    logic                F_pred_taken_o;
    logic [31:0]         mispredict_cnt_o;

    // Drives the controller (pipeline side / testbench).
    modport master (
        output F_stall_i, E_redirect_i, E_redirect_pc_i,
               E_train_valid_i, E_train_pc_i, E_train_taken_i,
               mini_op_branch_i, mini_op_jal_i, mini_jal_jmp_i, mini_branch_jmp_i,
        input  F_PC_o, F_valid_o, F_pred_taken_o, mispredict_cnt_o
    );

    // The controller itself.
    modport slave (
        input  F_stall_i, E_redirect_i, E_redirect_pc_i,
               E_train_valid_i, E_train_pc_i, E_train_taken_i,
               mini_op_branch_i, mini_op_jal_i, mini_jal_jmp_i, mini_branch_jmp_i,
        output F_PC_o, F_valid_o, F_pred_taken_o, mispredict_cnt_o
    );
endinterface

// File: rtl/fetch_pc_ctrl.sv
// Fetch-stage next-PC controller: owns the fetch PC and a bimodal BHT of
// 2-bit saturating counters, and picks the next PC from redirect, stall,
// jal and predicted-taken branches.
//
// state | meaning
// BOOT  | just out of reset; fetch word not valid, PC held at RESET_PC
// RUN   | normal fetch; PC advances by next-PC priority
module fetch_pc_ctrl #(
    parameter int                  PC_WIDTH    = 32,
    parameter int                  BHT_ENTRIES = 64,
    parameter logic [PC_WIDTH-1:0] RESET_PC    = 'h8000_0000
) (
    input  logic          clk,
    input  logic          rst,
    fetch_pc_ctrl_if.slave bus
);
    localparam int IDX_W = $clog2(BHT_ENTRIES);

    typedef enum logic {BOOT = 1'b0, RUN = 1'b1} state_t;

    state_t              state_q;
    state_t              state_d;
    logic                fetch_valid;
    logic [PC_WIDTH-1:0] pc_q;
    logic [PC_WIDTH-1:0] pc_d;
    logic [31:0]         mispredict_cnt_q;
    logic [1:0]          bht [BHT_ENTRIES];
    logic [IDX_W-1:0]    fetch_idx;
    logic [IDX_W-1:0]    train_idx;
    logic                pred_taken;
    logic                unused_train_pc_bits;

    assign fetch_idx  = pc_q[IDX_W+1:2];
    assign train_idx  = bus.E_train_pc_i[IDX_W+1:2];
    // Prediction reads the pre-update counter; training lands next edge.
    assign pred_taken = bus.mini_op_branch_i & bht[fetch_idx][1] & fetch_valid;

    assign unused_train_pc_bits = ^{bus.E_train_pc_i[PC_WIDTH-1:IDX_W+2],
                                    bus.E_train_pc_i[1:0]};

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state_q <= BOOT;
        else     state_q <= state_d;
    end

    // Next state: BOOT lasts exactly one cycle after reset.
    always_comb begin
        state_d = state_q;
        case (state_q)
            BOOT:    state_d = RUN;
            RUN:     state_d = RUN;
            default: state_d = BOOT;
        endcase
    end

    // FSM output: the fetch word is valid only in RUN.
    always_comb begin
        fetch_valid = (state_q == RUN);
    end

    // Next-PC select; redirect beats stall, jal beats predicted branch.
    always_comb begin
        pc_d = pc_q;
        if (fetch_valid) begin
            if (bus.E_redirect_i)       pc_d = bus.E_redirect_pc_i;
            else if (bus.F_stall_i)     pc_d = pc_q;
            else if (bus.mini_op_jal_i) pc_d = bus.mini_jal_jmp_i;
            else if (pred_taken)        pc_d = bus.mini_branch_jmp_i;
            else                        pc_d = pc_q + PC_WIDTH'(4);
        end
    end

    // Fetch PC register.
    always_ff @(posedge clk) begin
        if (rst) pc_q <= RESET_PC;
        else     pc_q <= pc_d;
    end

    // Redirect counter; redirects during BOOT are dropped and not counted.
    always_ff @(posedge clk) begin
        if (rst)                            mispredict_cnt_q <= '0;
        else if (fetch_valid && bus.E_redirect_i) mispredict_cnt_q <= mispredict_cnt_q + 32'd1;
    end

    // BHT training with saturation, independent of stall/redirect/state.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < BHT_ENTRIES; i++) bht[i] <= 2'b01;
        end else if (bus.E_train_valid_i) begin
            if (bus.E_train_taken_i) begin
                if (bht[train_idx] != 2'b11) bht[train_idx] <= bht[train_idx] + 2'b01;
            end else begin
                if (bht[train_idx] != 2'b00) bht[train_idx] <= bht[train_idx] - 2'b01;
            end
        end
    end

    assign bus.F_PC_o           = pc_q;
    assign bus.F_valid_o        = fetch_valid;
    assign bus.F_pred_taken_o   = pred_taken;
    assign bus.mispredict_cnt_o = mispredict_cnt_q;
endmodule

// File: tb/tb_fetch_pc_ctrl.sv
// Bench for fetch_pc_ctrl: directed vector table plus randomized run
// against a behavioural next-PC / BHT model.
module tb_fetch_pc_ctrl;
    localparam logic [31:0] R = 32'h8000_0000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fetch_pc_ctrl_if #(.PC_WIDTH(32)) bus ();

    fetch_pc_ctrl #(.PC_WIDTH(32), .BHT_ENTRIES(64), .RESET_PC(32'h8000_0000)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic        rst, stall, redir;
        logic [31:0] rpc;
        logic        jal;
        logic [31:0] jpc;
        logic        br;
        logic [31:0] bpc;
        logic        tv;
        logic [31:0] tpc;
        logic        tt;
        logic        e_pred;
        logic [31:0] e_pc;
        logic        e_valid;
        logic [31:0] e_cnt;
    } vec_t;

    vec_t tbl[$];
    int   total = 0;
    int   bad   = 0;

    // behavioural model state
    logic [31:0] m_pc;
    logic        m_valid;
    logic [31:0] m_cnt;
    int          m_bht[64];

    function automatic vec_t mk(logic r, logic s, logic rd, logic [31:0] rp,
                                logic j, logic [31:0] jp, logic b, logic [31:0] bp,
                                logic t, logic [31:0] tp, logic tk,
                                logic ep, logic [31:0] epc, logic ev, logic [31:0] ec);
        vec_t v;
        v.rst = r; v.stall = s; v.redir = rd; v.rpc = rp; v.jal = j; v.jpc = jp;
        v.br = b; v.bpc = bp; v.tv = t; v.tpc = tp; v.tt = tk;
        v.e_pred = ep; v.e_pc = epc; v.e_valid = ev; v.e_cnt = ec;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        rst                      = v.rst;
        bus.F_stall_i            = v.stall;
        bus.E_redirect_i         = v.redir;
        bus.E_redirect_pc_i      = v.rpc;
        bus.mini_op_jal_i        = v.jal;
        bus.mini_jal_jmp_i       = v.jpc;
        bus.mini_op_branch_i     = v.br;
        bus.mini_branch_jmp_i    = v.bpc;
        bus.E_train_valid_i      = v.tv;
        bus.E_train_pc_i         = v.tpc;
        bus.E_train_taken_i      = v.tt;
    endtask

    function automatic logic [31:0] pick();
        logic [31:0] p;
        if ($urandom_range(0, 9) == 0) p = 32'hFFFF_FFFC;
        else                           p = R + ($urandom_range(0, 15) << 2);
        return p;
    endfunction

    initial begin
        vec_t v;
        logic m_pred;
        int   ti;

        // rst stall redir rpc  jal jpc  br bpc  tv tpc tt | pred pc valid cnt
        tbl.push_back(mk(1,0,0,0,           0,0,       0,0,        0,0,     0, 0, R,            0, 0));
        tbl.push_back(mk(0,0,1,32'h1234,    0,0,       0,0,        0,0,     0, 0, R,            1, 0));
        tbl.push_back(mk(0,0,0,0,           0,0,       0,0,        0,0,     0, 0, R+4,          1, 0));
        tbl.push_back(mk(0,0,0,0,           0,0,       0,0,        0,0,     0, 0, R+8,          1, 0));
        tbl.push_back(mk(0,0,0,0,           1,R+'h10,  0,0,        0,0,     0, 0, R+'h10,       1, 0));
        tbl.push_back(mk(0,0,0,0,           0,0,       1,R+'h100,  0,0,     0, 0, R+'h14,       1, 0));
        tbl.push_back(mk(0,0,0,0,           0,0,       0,0,        1,R+'h10,1, 0, R+'h18,       1, 0));
        tbl.push_back(mk(0,0,0,0,           0,0,       0,0,        1,R+'h10,1, 0, R+'h1C,       1, 0));
        tbl.push_back(mk(0,0,1,R+'h10,      0,0,       0,0,        0,0,     0, 0, R+'h10,       1, 1));
        tbl.push_back(mk(0,0,0,0,           0,0,       1,R+'h100,  1,R+'h10,1, 1, R+'h100,      1, 1));
        tbl.push_back(mk(0,0,1,R+'h10,      0,0,       0,0,        0,0,     0, 0, R+'h10,       1, 2));
        tbl.push_back(mk(0,0,0,0,           0,0,       1,R+'h100,  1,R+'h10,0, 1, R+'h100,      1, 2));
        tbl.push_back(mk(0,1,0,0,           1,R+'h200, 0,0,        0,0,     0, 0, R+'h100,      1, 2));
        tbl.push_back(mk(0,1,0,0,           1,R+'h200, 0,0,        0,0,     0, 0, R+'h100,      1, 2));
        tbl.push_back(mk(0,1,0,0,           1,R+'h200, 0,0,        0,0,     0, 0, R+'h100,      1, 2));
        tbl.push_back(mk(0,0,0,0,           1,R+'h200, 0,0,        0,0,     0, 0, R+'h200,      1, 2));
        tbl.push_back(mk(0,1,1,R+'h400,     1,R+'h200, 0,0,        0,0,     0, 0, R+'h400,      1, 3));
        tbl.push_back(mk(0,0,1,32'hFFFF_FFFC,0,0,      0,0,        0,0,     0, 0, 32'hFFFF_FFFC,1, 4));
        tbl.push_back(mk(0,0,0,0,           0,0,       0,0,        0,0,     0, 0, 32'h0,        1, 4));
        tbl.push_back(mk(0,1,0,0,           0,0,       1,32'h500,  1,32'h0, 1, 0, 32'h0,        1, 4));
        tbl.push_back(mk(0,0,0,0,           0,0,       1,32'h500,  0,0,     0, 1, 32'h500,      1, 4));
        tbl.push_back(mk(1,0,1,32'h700,     0,0,       0,0,        1,32'h0, 1, 0, R,            0, 0));
        tbl.push_back(mk(0,0,0,0,           0,0,       0,0,        0,0,     0, 0, R,            1, 0));
        tbl.push_back(mk(0,0,0,0,           1,R+'h10,  0,0,        0,0,     0, 0, R+'h10,       1, 0));
        tbl.push_back(mk(0,0,0,0,           0,0,       1,R+'h100,  0,0,     0, 0, R+'h14,       1, 0));
        tbl.push_back(mk(0,0,1,32'h0,       0,0,       0,0,        0,0,     0, 0, 32'h0,        1, 1));
        tbl.push_back(mk(0,0,0,0,           0,0,       1,32'h500,  0,0,     0, 0, 32'h4,        1, 1));

        foreach (tbl[i]) begin
            drive(tbl[i]);
            #1;
            check($sformatf("vec%0d pred", i), 32'(bus.F_pred_taken_o), 32'(tbl[i].e_pred));
            @(posedge clk);
            #1;
            check($sformatf("vec%0d pc", i),    bus.F_PC_o,              tbl[i].e_pc);
            check($sformatf("vec%0d valid", i), 32'(bus.F_valid_o),      32'(tbl[i].e_valid));
            check($sformatf("vec%0d cnt", i),   bus.mispredict_cnt_o,    tbl[i].e_cnt);
        end

        // Randomized run; the first cycle is a reset to align the model.
        m_pc = '0; m_valid = 1'b0; m_cnt = '0;
        for (int k = 0; k < 64; k++) m_bht[k] = 1;
        for (int i = 0; i < 600; i++) begin
            v.rst   = (i == 0) || ($urandom_range(0, 49) == 0);
            v.stall = ($urandom_range(0, 3) == 0);
            v.redir = ($urandom_range(0, 7) == 0);
            v.rpc   = pick();
            v.jal   = ($urandom_range(0, 5) == 0);
            v.jpc   = pick();
            v.br    = 1'($urandom_range(0, 1));
            v.bpc   = pick();
            v.tv    = 1'($urandom_range(0, 1));
            v.tpc   = pick();
            v.tt    = ($urandom_range(0, 2) != 0);
            drive(v);
            #1;
            m_pred = m_valid && v.br && (m_bht[(m_pc >> 2) % 64] >= 2);
            if (i != 0) check("rand pred", 32'(bus.F_pred_taken_o), 32'(m_pred));

            if (v.rst) begin
                m_pc = R; m_valid = 1'b0; m_cnt = '0;
                for (int k = 0; k < 64; k++) m_bht[k] = 1;
            end else begin
                if (m_valid) begin
                    if (v.redir)      begin m_pc = v.rpc; m_cnt = m_cnt + 1; end
                    else if (v.stall) m_pc = m_pc;
                    else if (v.jal)   m_pc = v.jpc;
                    else if (m_pred)  m_pc = v.bpc;
                    else              m_pc = m_pc + 4;
                end
                m_valid = 1'b1;
                if (v.tv) begin
                    ti = int'((v.tpc >> 2) % 64);
                    if (v.tt) m_bht[ti] = (m_bht[ti] == 3) ? 3 : m_bht[ti] + 1;
                    else      m_bht[ti] = (m_bht[ti] == 0) ? 0 : m_bht[ti] - 1;
                end
            end

            @(posedge clk);
            #1;
            check("rand pc",    bus.F_PC_o,           m_pc);
            check("rand valid", 32'(bus.F_valid_o),   32'(m_valid));
            check("rand cnt",   bus.mispredict_cnt_o, m_cnt);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
